// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM encoding and digit check
package bcd_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_ADJ  = 4'd6;
    localparam logic       MODE_ADD = 1'b0;
    localparam logic       MODE_SUB = 1'b1;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - one-digit BCD add/sub cell; subtract uses nine's complement of b
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] w_yd;
    logic [4:0] w_sum;

    always_comb begin
        w_yd  = (sub == MODE_ADD) ? b : (BCD_NINE - b);
        w_sum = {1'b0, a} + {1'b0, w_yd} + {4'b0, cin};
        if (w_sum > 5'd9) begin
            s    = w_sum[3:0] + BCD_ADJ;
            cout = 1'b1;
        end else begin
            s    = w_sum[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_addsub_seq_ctrl.sv
// rtl/bcd_addsub_seq_ctrl.sv - digit-serial packed-BCD add/sub sequencer with ready/valid handshakes
module bcd_addsub_seq_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIG = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_x,
    input  logic [4*NDIG-1:0] in_y,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_r,
    output logic              out_kout,
    output logic              out_err,
    output logic              busy
);

    localparam int              IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]   LAST = IW'(NDIG - 1);

    logic [1:0]        r_state;
    logic [4*NDIG-1:0] r_x, r_y, r_res;
    logic              r_mode, r_carry, r_kout, r_err;
    logic [IW-1:0]     r_idx;

    logic              w_bad;
    logic [3:0]        w_xd, w_yd, w_sd;
    logic              w_cout;

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd_digit(in_x[4*i +: 4]) || !is_bcd_digit(in_y[4*i +: 4]))
                w_bad = 1'b1;
        end
    end

    always_comb begin
        w_xd = '0;
        w_yd = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_xd = r_x[4*i +: 4];
                w_yd = r_y[4*i +: 4];
            end
        end
    end

    bcd_digit_addsub u_cell (
        .a    (w_xd),
        .b    (w_yd),
        .cin  (r_carry),
        .sub  (r_mode),
        .s    (w_sd),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_mode  <= 1'b0;
            r_res   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_kout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_x;
                        r_y     <= in_y;
                        r_mode  <= in_mode;
                        r_res   <= '0;
                        r_idx   <= '0;
                        // ten's complement: nine's complement per digit plus an initial carry
                        r_carry <= (in_mode == MODE_SUB);
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_kout  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (r_idx == IW'(i))
                            r_res[4*i +: 4] <= w_sd;
                    end
                    r_carry <= w_cout;
                    if (r_idx == LAST) begin
                        r_kout  <= w_cout;
                        r_err   <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_r     = r_res;
    assign out_kout  = r_kout;
    assign out_err   = r_err;

endmodule

// File: tb/tb_bcd_addsub_seq_ctrl.sv
// tb/tb_bcd_addsub_seq_ctrl.sv - directed table-driven bench for bcd_addsub_seq_ctrl
module tb_bcd_addsub_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_x, in_y;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_r;
    logic        out_kout;
    logic        out_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        mode;
        logic [11:0] r;
        logic        k;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    bcd_addsub_seq_ctrl #(.NDIG(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_kout  (out_kout),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one op starting just after a rising edge; returns once out_valid is seen (or timeout).
    task automatic issue_and_wait(input logic [11:0] x, input logic [11:0] y, input logic mode,
                                  input string name, output int lat, output logic saw_ready);
        check({name, " in_ready before"}, in_ready, 1);
        in_x     = x;
        in_y     = y;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_x      = 12'hFFF;
        in_y      = 12'hFFF;
        in_mode   = ~mode;
        lat       = 0;
        saw_ready = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic        saw_ready;

        vecs[0] = '{12'h999, 12'h999, 1'b0, 12'h998, 1'b1, 1'b0, 3};
        vecs[1] = '{12'h548, 12'h459, 1'b0, 12'h007, 1'b1, 1'b0, 3};
        vecs[2] = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 3};
        vecs[3] = '{12'h999, 12'h999, 1'b1, 12'h000, 1'b1, 1'b0, 3};
        vecs[4] = '{12'h569, 12'h568, 1'b1, 12'h001, 1'b1, 1'b0, 3};
        vecs[5] = '{12'h108, 12'h051, 1'b1, 12'h057, 1'b1, 1'b0, 3};
        vecs[6] = '{12'h387, 12'h616, 1'b1, 12'h771, 1'b0, 1'b0, 3};
        vecs[7] = '{12'h765, 12'h943, 1'b1, 12'h822, 1'b0, 1'b0, 3};
        vecs[8] = '{12'h9A5, 12'h001, 1'b0, 12'h000, 1'b0, 1'b1, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_r", out_r, 0);
        check("reset out_kout", out_kout, 0);
        check("reset out_err", out_err, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue_and_wait(vecs[i].x, vecs[i].y, vecs[i].mode, nm, lat, saw_ready);
            check({nm, " latency"}, lat, vecs[i].lat);
            check({nm, " out_r"}, out_r, vecs[i].r);
            check({nm, " out_kout"}, out_kout, vecs[i].k);
            check({nm, " out_err"}, out_err, vecs[i].err);
            check({nm, " in_ready while busy"}, saw_ready | in_ready, 0);
            check({nm, " busy in DONE"}, busy, 1);
            @(posedge clk);
            #1;
            check({nm, " out_valid after xfer"}, out_valid, 0);
            check({nm, " in_ready after xfer"}, in_ready, 1);
        end

        // Backpressure: result held while out_ready is low, new requests ignored
        out_ready = 1'b0;
        issue_and_wait(12'h123, 12'h456, 1'b0, "bp", lat, saw_ready);
        check("bp latency", lat, 3);
        for (int c = 0; c < 5; c++) begin
            in_valid = (c == 2);
            in_x     = 12'h111;
            in_y     = 12'h222;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp hold out_r c%0d", c), out_r, 12'h579);
            check($sformatf("bp hold out_valid c%0d", c), out_valid, 1);
            check($sformatf("bp hold in_ready c%0d", c), in_ready, 0);
        end
        check("bp out_kout", out_kout, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp out_valid after xfer", out_valid, 0);
        check("bp in_ready after xfer", in_ready, 1);
        check("bp out_r kept in IDLE", out_r, 12'h579);
        @(posedge clk);
        #1;
        check("bp ignored op not started", busy, 0);

        // Asynchronous reset one cycle after accepting an op
        in_x     = 12'h548;
        in_y     = 12'h459;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst mid busy before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rst mid in_ready", in_ready, 1);
        check("rst mid out_valid", out_valid, 0);
        check("rst mid busy", busy, 0);
        check("rst mid out_r", out_r, 0);
        check("rst mid out_kout", out_kout, 0);
        check("rst mid out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue_and_wait(12'h001, 12'h001, 1'b0, "post rst", lat, saw_ready);
        check("post rst latency", lat, 3);
        check("post rst out_r", out_r, 12'h002);
        check("post rst out_kout", out_kout, 0);
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
